prog_loader: RTL and testbench

- Boot-time image loader upstream of the VeriRISC cpu.
- Accepts a byte stream over a valid/ready handshake and writes it sequentially into the 32x8 program memory from address 0.
- Holds the cpu in reset until the image is complete, then releases it and watches the cpu halt output.
- Shares the program memory write port with the cpu. An external mux selects the loader whenever cpu_rst is high.

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader_if.sv | 39 +++
 rtl/prog_loader_addr_ctr.sv | 37 +++
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int LOADER_DEPTH  = 32;
    localparam int LOADER_ADDR_W = 5;
    localparam int LOADER_DATA_W = 8;
    localparam int CSUM_W        = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        HALTED  = 3'd4,
        ERROR   = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Stream, program-memory write and cpu control bundle of the
//               loader. master = loader side, slave = system side.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = LOADER_DATA_W
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_rst;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, in_valid, in_data, in_last, cpu_halt,
        output in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, error
    );

    modport slave (
        output start, in_valid, in_data, in_last, cpu_halt,
        input  in_ready, mem_wr, mem_addr, mem_data, cpu_rst, busy, done, error
    );

endinterface
`default_nettype wire

// File: rtl/prog_loader_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : loader_addr_ctr
// Description : Write address / byte counter, one bit wider than the address
//               so a full memory is distinguishable from an empty one.
// Revision    : 1.0 - initial release
// ============================================================================
module loader_addr_ctr #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               i_clear,
    input  wire               i_inc,
    output logic [ADDR_W:0]   o_count,
    output logic              o_last_addr
);

    localparam logic [ADDR_W:0] c_last = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_one  = (ADDR_W+1)'(1);

    logic [ADDR_W:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count     = r_count;
    assign o_last_addr = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot image loader: streams bytes into program memory, holds
//               the cpu in reset until loaded, then watches for halt.
//               Optional macro PROG_LOADER_CHECKSUM_EN: final beat is a
//               mod-256 checksum byte instead of image data.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = LOADER_DATA_W,
    parameter int DEPTH  = LOADER_DEPTH
) (
    input  wire           clk,
    input  wire           rst,
    prog_loader_if.master bus
);

    loader_state_t     r_state;
    logic              r_in_ready;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic [ADDR_W:0]   w_count;
    logic              w_last_addr;
    logic              w_full;
    logic              w_beat;
    logic              w_wr_beat;
    logic              w_to_release;
    logic              w_to_error;
    logic              w_start_ok;

    assign w_beat     = bus.in_valid & r_in_ready;
    // DEPTH is a power of two, so the count's top bit means "memory full"
    assign w_full     = w_count[ADDR_W];
    assign w_start_ok = bus.start &
                        ((r_state == IDLE) || (r_state == HALTED) || (r_state == ERROR));

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] r_sum;
    logic [CSUM_W-1:0] w_sum_next;
    logic              w_sum_ok;

    assign w_sum_next   = r_sum + CSUM_W'(bus.in_data);
    assign w_sum_ok     = (w_sum_next == '0);
    assign w_wr_beat    = w_beat & ~bus.in_last & ~w_full;
    assign w_to_release = w_beat & bus.in_last & w_sum_ok;
    assign w_to_error   = w_beat & ((bus.in_last & ~w_sum_ok) | (~bus.in_last & w_full));

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_sum <= '0;
        end else if (w_wr_beat) begin
            r_sum <= w_sum_next;
        end
    end
`else
    assign w_wr_beat    = w_beat & ~w_full;
    assign w_to_release = w_beat & bus.in_last;
    assign w_to_error   = w_beat & ~bus.in_last & w_last_addr;
`endif

    loader_addr_ctr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok),
        .i_inc       (w_wr_beat),
        .o_count     (w_count),
        .o_last_addr (w_last_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // Writes trail their accepting edge by exactly one cycle
            r_mem_wr <= w_wr_beat;
            if (w_wr_beat) begin
                r_mem_addr <= w_count[ADDR_W-1:0];
                r_mem_data <= bus.in_data;
            end

            case (r_state)
                IDLE, HALTED, ERROR: begin
                    if (w_start_ok) begin
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                        r_cpu_rst  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_to_release) begin
                        r_state    <= RELEASE;
                        r_in_ready <= 1'b0;
                    end else if (w_to_error) begin
                        r_state    <= ERROR;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                    end
                end
                RELEASE: begin
                    r_state   <= RUN;
                    r_cpu_rst <= 1'b0;
                    r_busy    <= 1'b0;
                end
                RUN: begin
                    if (bus.cpu_halt) begin
                        r_state <= HALTED;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_cpu_rst  <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_error    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.mem_wr   = r_mem_wr;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.cpu_rst  = r_cpu_rst;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader: behavioural model,
//               per-cycle compare and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int DEPTH = 32;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3, P_HALT = 4, P_ERR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    prog_loader #(.ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   ph = P_IDLE;
    int   m_cnt = 0;
    int   m_sum = 0;
    int   cyc = 0;
    bit   started = 1'b0;
    logic e_in_ready = 1'b0, e_cpu_rst = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_error = 1'b0;
    logic e_wr = 1'b0;
    int   e_addr = 0, e_data = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
        if (rst) begin
            ph <= P_IDLE; m_cnt <= 0; m_sum <= 0;
            e_in_ready <= 1'b0; e_cpu_rst <= 1'b1; e_busy <= 1'b0;
            e_done <= 1'b0; e_error <= 1'b0; e_wr <= 1'b0; e_addr <= 0; e_data <= 0;
        end else begin
            e_wr <= 1'b0;
            case (ph)
                P_IDLE, P_HALT, P_ERR: if (bus.start === 1'b1) begin
                    ph <= P_LOAD; m_cnt <= 0; m_sum <= 0;
                    e_in_ready <= 1'b1; e_cpu_rst <= 1'b1; e_busy <= 1'b1;
                    e_done <= 1'b0; e_error <= 1'b0;
                end
                P_LOAD: if (bus.in_valid === 1'b1) begin
                    if (CSUM && bus.in_last) begin
                        if (((m_sum + int'(bus.in_data)) % 256) == 0) begin
                            ph <= P_REL; e_in_ready <= 1'b0;
                        end else begin
                            ph <= P_ERR; e_in_ready <= 1'b0; e_busy <= 1'b0; e_error <= 1'b1;
                        end
                    end else if (m_cnt >= DEPTH) begin
                        ph <= P_ERR; e_in_ready <= 1'b0; e_busy <= 1'b0; e_error <= 1'b1;
                    end else begin
                        e_wr <= 1'b1; e_addr <= m_cnt; e_data <= int'(bus.in_data);
                        m_cnt <= m_cnt + 1;
                        m_sum <= (m_sum + int'(bus.in_data)) % 256;
                        if (bus.in_last) begin
                            ph <= P_REL; e_in_ready <= 1'b0;
                        end else if (!CSUM && m_cnt == DEPTH - 1) begin
                            ph <= P_ERR; e_in_ready <= 1'b0; e_busy <= 1'b0; e_error <= 1'b1;
                        end
                    end
                end
                P_REL: begin
                    ph <= P_RUN; e_cpu_rst <= 1'b0; e_busy <= 1'b0;
                end
                P_RUN: if (bus.cpu_halt === 1'b1) begin
                    ph <= P_HALT; e_done <= 1'b1;
                end
                default: ph <= P_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    int lg_addr[$];
    int lg_data[$];
    int lg_cyc[$];

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 32'(bus.in_ready), 32'(e_in_ready));
            chk("cpu_rst",  32'(bus.cpu_rst),  32'(e_cpu_rst));
            chk("busy",     32'(bus.busy),     32'(e_busy));
            chk("done",     32'(bus.done),     32'(e_done));
            chk("error",    32'(bus.error),    32'(e_error));
            chk("mem_wr",   32'(bus.mem_wr),   32'(e_wr));
            if (e_wr) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
                chk("mem_data", 32'(bus.mem_data), 32'(e_data));
            end
            if (bus.mem_wr === 1'b1) begin
                lg_addr.push_back(int'(bus.mem_addr));
                lg_data.push_back(int'(bus.mem_data));
                lg_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_halt();
        bus.cpu_halt = 1'b1;
        tick();
        bus.cpu_halt = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = (e_in_ready === 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic clear_log();
        lg_addr.delete();
        lg_data.delete();
        lg_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] img [4];
        img = '{8'hA0, 8'h21, 8'hE0, 8'h00};
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        bus.in_last = 1'b0; bus.cpu_halt = 1'b0;

        // reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_cpu_rst",  32'(bus.cpu_rst),  32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_wr",   32'(bus.mem_wr),   32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);

`ifndef PROG_LOADER_CHECKSUM_EN
        // basic load
        clear_log();
        pulse_start();
        chk("basic_ready_up", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) send(img[i], i == 3);
        chk("release_busy",   32'(bus.busy),     32'd1);
        chk("release_cpurst", 32'(bus.cpu_rst),  32'd1);
        chk("release_ready",  32'(bus.in_ready), 32'd0);
        tick();
        chk("run_cpurst", 32'(bus.cpu_rst), 32'd0);
        chk("basic_nwr", 32'(lg_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < lg_addr.size(); i++) begin
            chk("basic_addr", 32'(lg_addr[i]), 32'(i));
            chk("basic_data", 32'(lg_data[i]), 32'(img[i]));
            chk("basic_cyc",  32'(lg_cyc[i] - lg_cyc[0]), 32'(i));
        end
        pulse_start();
        chk("run_ignores_start", 32'(bus.busy), 32'd0);
        pulse_halt();
        chk("halted_done", 32'(bus.done), 32'd1);
        chk("halted_cpurst", 32'(bus.cpu_rst), 32'd0);

        // throttled stream: valid 1,0,0,1,1
        clear_log();
        pulse_start();
        chk("restart_cpurst", 32'(bus.cpu_rst), 32'd1);
        chk("restart_done",   32'(bus.done),    32'd0);
        send(8'h11, 1'b0);
        tick(); tick();
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        tick();
        chk("thr_nwr", 32'(lg_addr.size()), 32'd3);
        if (lg_addr.size() == 3) begin
            chk("thr_addr2", 32'(lg_addr[2]), 32'd2);
            chk("thr_data1", 32'(lg_data[1]), 32'h22);
            chk("thr_gap",   32'(lg_cyc[2] - lg_cyc[0]), 32'd4);
        end
        pulse_halt();

        // overflow
        clear_log();
        pulse_start();
        for (int i = 0; i < DEPTH; i++) send(8'(i ^ 8'h5C), 1'b0);
        chk("ovf_error",  32'(bus.error),    32'd1);
        chk("ovf_ready",  32'(bus.in_ready), 32'd0);
        chk("ovf_cpurst", 32'(bus.cpu_rst),  32'd1);
        chk("ovf_last_addr", 32'(bus.mem_addr), 32'd31);
        tick();
        chk("ovf_nwr", 32'(lg_addr.size()), 32'd32);
        pulse_start();
        chk("ovf_restart_busy", 32'(bus.busy), 32'd1);
        chk("ovf_restart_err",  32'(bus.error), 32'd0);
        send(8'h77, 1'b0);
        chk("ovf_restart_addr", 32'(bus.mem_addr), 32'd0);

        // reset mid-load
        rst = 1'b1; tick(); rst = 1'b0;
        clear_log();
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'(8'hC0 + i), 1'b0);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'hC3;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_ready",  32'(bus.in_ready), 32'd0);
        chk("mid_rst_cpurst", 32'(bus.cpu_rst),  32'd1);
        chk("mid_rst_wr",     32'(bus.mem_wr),   32'd0);
        chk("mid_rst_busy",   32'(bus.busy),     32'd0);
        chk("mid_rst_addr",   32'(bus.mem_addr), 32'd0);
        tick(); tick();
        chk("mid_rst_nwr", 32'(lg_addr.size()), 32'd3);
        pulse_start();
        send(8'h5A, 1'b1);
        chk("reload_addr", 32'(bus.mem_addr), 32'd0);
        chk("reload_data", 32'(bus.mem_data), 32'h5A);
        tick(); tick();
`else
        // checksum accepted
        clear_log();
        pulse_start();
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'hD0, 1'b1);
        chk("csum_ok_nowr", 32'(bus.mem_wr), 32'd0);
        tick();
        chk("csum_ok_cpurst", 32'(bus.cpu_rst), 32'd0);
        chk("csum_ok_nwr", 32'(lg_addr.size()), 32'd2);
        pulse_halt();
        chk("csum_done", 32'(bus.done), 32'd1);

        // checksum rejected
        clear_log();
        pulse_start();
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'hD1, 1'b1);
        chk("csum_bad_error", 32'(bus.error), 32'd1);
        chk("csum_bad_cpurst", 32'(bus.cpu_rst), 32'd1);
        tick();
        chk("csum_bad_nwr", 32'(lg_addr.size()), 32'd2);

        // overflow: DEPTH data bytes then one more non-last beat
        clear_log();
        pulse_start();
        for (int i = 0; i <= DEPTH; i++) send(8'(i), 1'b0);
        chk("csum_ovf_error", 32'(bus.error), 32'd1);
        tick();
        chk("csum_ovf_nwr", 32'(lg_addr.size()), 32'd32);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
